// File: rtl/rpsc_pkg.sv
// Shared types and constants for the RPSC interlock conditioner.
package rpsc_pkg;

  localparam int unsigned FirstIdxW = 5;
  localparam int unsigned TripCntW  = 8;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [FirstIdxW-1:0] lowest_idx(input logic [31:0] v);
    logic [FirstIdxW-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = FirstIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// Single interlock channel: 2-flop synchroniser followed by a stability
// counter; the filtered level only moves after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it.
module rpsc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ok_filt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  // Count disagreeing samples; any agreeing sample restarts the window.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and filtered level; fail-safe low out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign ok_filt = filt_q;

endmodule

// File: rtl/rpsc_interlock_cond.sv
// Interlock input conditioner ahead of RPSC card 1: debounces the field
// interlocks, latches unmasked losses, records the first trip and drives a
// registered Not_Alarm summary. Optional per-channel trip counters are built
// when RPSC_TRIP_COUNT_EN is defined.
module rpsc_interlock_cond
  import rpsc_pkg::*;
#(
  parameter int unsigned N_CH            = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      i_raw,
  input  logic [N_CH-1:0]      i_mask,
  input  logic                 i_ack,
  output logic [N_CH-1:0]      o_ok_filt,
  output logic [N_CH-1:0]      o_fault_latched,
  output logic [FirstIdxW-1:0] o_first_fault,
  output logic                 o_first_valid,
  output logic                 o_not_alarm,
  output logic [1:0]           o_state
`ifdef RPSC_TRIP_COUNT_EN
  ,
  output logic [N_CH*TripCntW-1:0] o_trip_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(DEBOUNCE_CYCLES + 2);

  logic [N_CH-1:0]      ok_filt;
  logic [N_CH-1:0]      bad;
  logic [FirstIdxW-1:0] bad_idx;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [N_CH-1:0]      latch_q, latch_d;
  logic [FirstIdxW-1:0] first_q, first_d;
  logic                 valid_q, valid_d;
  logic                 na_q, na_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    rpsc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (i_raw[k]),
      .ok_filt(ok_filt[k])
    );
  end

  assign bad     = ~ok_filt & ~i_mask;
  assign bad_idx = lowest_idx(32'(bad));

  // Next-state logic for the settle/run/fault sequencer and fault record.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    latch_d  = latch_q;
    first_d  = first_q;
    valid_d  = valid_q;
    na_d     = 1'b0;
    case (state_q)
      StInit: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          if (bad == '0) begin
            state_d = StRun;
            na_d    = 1'b1;
          end else begin
            state_d = StFault;
            latch_d = bad;
            first_d = bad_idx;
            valid_d = 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRun: begin
        na_d = 1'b1;
        if (bad != '0) begin
          state_d = StFault;
          na_d    = 1'b0;
          latch_d = latch_q | bad;
          if (!valid_q) begin
            first_d = bad_idx;
            valid_d = 1'b1;
          end
        end
      end
      StFault: begin
        if (i_ack) begin
          // Ack drops every latched channel that is no longer bad.
          latch_d = latch_q & bad;
          if ((latch_d == '0) && (bad == '0)) begin
            state_d = StRun;
            na_d    = 1'b1;
            valid_d = 1'b0;
            first_d = '0;
          end
        end else begin
          latch_d = latch_q | bad;
        end
      end
      default: begin
        state_d = StFault;
        latch_d = latch_q | bad;
      end
    endcase
  end

  // Sequencer and fault-record registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StInit;
      settle_q <= '0;
      latch_q  <= '0;
      first_q  <= '0;
      valid_q  <= 1'b0;
      na_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      latch_q  <= latch_d;
      first_q  <= first_d;
      valid_q  <= valid_d;
      na_q     <= na_d;
    end
  end

  assign o_ok_filt       = ok_filt;
  assign o_fault_latched = latch_q;
  assign o_first_fault   = first_q;
  assign o_first_valid   = valid_q;
  assign o_not_alarm     = na_q;
  assign o_state         = state_q;

`ifdef RPSC_TRIP_COUNT_EN
  logic [N_CH*TripCntW-1:0] trip_q, trip_d;

  // Saturating count of 0->1 transitions of each latched bit.
  always_comb begin
    trip_d = trip_q;
    for (int k = 0; k < N_CH; k++) begin
      if (latch_d[k] && !latch_q[k] && (trip_q[k*TripCntW +: TripCntW] != '1)) begin
        trip_d[k*TripCntW +: TripCntW] = trip_q[k*TripCntW +: TripCntW] + 1'b1;
      end
    end
  end

  // Trip counters survive acknowledge; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trip_q <= '0;
    end else begin
      trip_q <= trip_d;
    end
  end

  assign o_trip_count = trip_q;
`endif

endmodule

// File: tb/tb_rpsc_interlock_cond.sv
// Directed bench for rpsc_interlock_cond with N_CH=8, DEBOUNCE_CYCLES=4.
module tb_rpsc_interlock_cond;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw = 8'hFF;
  logic [7:0] mask = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] ok_filt;
  logic [7:0] fault_latched;
  logic [4:0] first_fault;
  logic       first_valid;
  logic       not_alarm;
  logic [1:0] state;
`ifdef RPSC_TRIP_COUNT_EN
  logic [63:0] trip_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  rpsc_interlock_cond #(
    .N_CH           (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_raw          (raw),
    .i_mask         (mask),
    .i_ack          (ack),
    .o_ok_filt      (ok_filt),
    .o_fault_latched(fault_latched),
    .o_first_fault  (first_fault),
    .o_first_valid  (first_valid),
    .o_not_alarm    (not_alarm),
    .o_state        (state)
`ifdef RPSC_TRIP_COUNT_EN
    ,
    .o_trip_count   (trip_count)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef RPSC_TRIP_COUNT_EN
  task automatic trip_ch0();
    raw = 8'hFE;
    tick(7);
    raw = 8'hFF;
    tick(6);
    ack_pulse();
  endtask
`endif

  initial begin
    // Reset values and the INIT settle window.
    tick(2);
    check_val("rst_filt", ok_filt, 8'h00);
    check_val("rst_latch", fault_latched, 8'h00);
    check_val("rst_first", first_fault, 5'd0);
    check_val("rst_valid", first_valid, 1'b0);
    check_val("rst_na", not_alarm, 1'b0);
    check_val("rst_state", state, 2'd0);
    reset = 1'b0;
    tick(5);
    check_val("init_filt_c5", ok_filt, 8'h00);
    tick(1);
    check_val("init_filt_c6", ok_filt, 8'hFF);
    check_val("init_state_c6", state, 2'd0);
    check_val("init_na_c6", not_alarm, 1'b0);
    tick(1);
    check_val("run_state_c7", state, 2'd1);
    check_val("run_na_c7", not_alarm, 1'b1);

    // Short glitch on channel 3 is rejected.
    raw = 8'hF7;
    tick(3);
    raw = 8'hFF;
    tick(8);
    check_val("glitch_filt", ok_filt, 8'hFF);
    check_val("glitch_na", not_alarm, 1'b1);
    check_val("glitch_latch", fault_latched, 8'h00);

    // Sustained loss on channel 3.
    raw = 8'hF7;
    tick(5);
    check_val("trip3_filt_c5", ok_filt, 8'hFF);
    tick(1);
    check_val("trip3_filt_c6", ok_filt, 8'hF7);
    check_val("trip3_na_c6", not_alarm, 1'b1);
    tick(1);
    check_val("trip3_latch", fault_latched, 8'h08);
    check_val("trip3_first", first_fault, 5'd3);
    check_val("trip3_valid", first_valid, 1'b1);
    check_val("trip3_na", not_alarm, 1'b0);
    check_val("trip3_state", state, 2'd2);

    // Ack while still bad keeps the fault.
    ack_pulse();
    check_val("ack_bad_latch", fault_latched, 8'h08);
    check_val("ack_bad_state", state, 2'd2);
    check_val("ack_bad_first", first_fault, 5'd3);
    raw = 8'hFF;
    tick(6);
    check_val("recover_filt", ok_filt, 8'hFF);
    ack_pulse();
    check_val("ack_ok_state", state, 2'd1);
    check_val("ack_ok_na", not_alarm, 1'b1);
    check_val("ack_ok_valid", first_valid, 1'b0);
    check_val("ack_ok_first", first_fault, 5'd0);
    check_val("ack_ok_latch", fault_latched, 8'h00);

    // Simultaneous trips on channels 5 and 2: lowest index wins.
    raw = 8'hDB;
    tick(6);
    check_val("sim_filt", ok_filt, 8'hDB);
    tick(1);
    check_val("sim_latch", fault_latched, 8'h24);
    check_val("sim_first", first_fault, 5'd2);
    check_val("sim_valid", first_valid, 1'b1);
    raw = 8'hFF;
    tick(6);
    ack_pulse();
    check_val("sim_ack_state", state, 2'd1);

    // Mask a latched channel, then ack clears it.
    raw = 8'hBF;
    tick(7);
    check_val("ch6_latch", fault_latched, 8'h40);
    check_val("ch6_first", first_fault, 5'd6);
    check_val("ch6_state", state, 2'd2);
    mask = 8'h40;
    tick(1);
    check_val("mask_latch_held", fault_latched, 8'h40);
    ack_pulse();
    check_val("mask_ack_state", state, 2'd1);
    check_val("mask_ack_latch", fault_latched, 8'h00);
    check_val("mask_ack_na", not_alarm, 1'b1);
    raw = 8'hFF;
    tick(8);
    raw = 8'hBF;
    tick(8);
    check_val("mask_tog_filt", ok_filt, 8'hBF);
    check_val("mask_tog_na", not_alarm, 1'b1);
    check_val("mask_tog_latch", fault_latched, 8'h00);
    check_val("mask_tog_state", state, 2'd1);

    // Mid-operation reset forces a full re-settle.
    reset = 1'b1;
    #1;
    check_val("mid_rst_state", state, 2'd0);
    check_val("mid_rst_na", not_alarm, 1'b0);
    check_val("mid_rst_filt", ok_filt, 8'h00);
    mask = 8'h00;
    raw = 8'hFF;
    tick(1);
    reset = 1'b0;
    tick(6);
    check_val("resettle_state_c6", state, 2'd0);
    tick(1);
    check_val("resettle_state_c7", state, 2'd1);
    check_val("resettle_na_c7", not_alarm, 1'b1);

`ifdef RPSC_TRIP_COUNT_EN
    for (int i = 0; i < 3; i++) trip_ch0();
    check_val("trip_cnt_3", trip_count[7:0], 8'd3);
    check_val("trip_cnt_others", trip_count[63:8], 56'd0);
    for (int i = 0; i < 297; i++) trip_ch0();
    check_val("trip_cnt_sat", trip_count[7:0], 8'd255);
    reset = 1'b1;
    #1;
    check_val("trip_cnt_rst", trip_count, 64'd0);
    tick(1);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
